seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller that shares one BCD-to-7-segment decoder across N_DIGITS digits.

---
 rtl/seg_scan_ctrl_if.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake and display bus of the seven-segment scan controller.
// The slave modport is the scan controller. The master modport is its environment,
// meaning the load source and the shared BCD-to-7-segment decoder.
interface seg_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                  load_valid;
    logic [4*N_DIGITS-1:0] load_data;
    logic                  load_ready;
    logic [3:0]            bcd_code;
    logic [6:0]            seg_in;
    logic [6:0]            seg_out;
    logic [N_DIGITS-1:0]   an_out;
    logic                  frame_done;

    modport slave (
        input  load_valid,
        input  load_data,
        input  seg_in,
        output load_ready,
        output bcd_code,
        output seg_out,
        output an_out,
        output frame_done
    );

    modport master (
        output load_valid,
        output load_data,
        output seg_in,
        input  load_ready,
        input  bcd_code,
        input  seg_out,
        input  an_out,
        input  frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for N_DIGITS seven-segment digits.
// All digits share one external BCD decoder. Each digit slot begins with a blanking gap
// to prevent ghosting. New values arrive over a valid/ready handshake and are committed
// only at frame boundaries.
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
// With leading-zero blanking, digit 0 is always shown.
module seg_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW    = 4 * N_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic                slot_end;
    logic                wrap;
    logic [DW-1:0]       active, active_next;
    logic [DW-1:0]       pending, pending_next;
    logic                pend_flag, pend_flag_next;
    logic                xfer;
    logic [3:0]          bcd_reg, bcd_next;
    logic [6:0]          seg_reg, seg_next;
    logic [N_DIGITS-1:0] an_reg, an_next;
    logic                fd_reg;
`ifdef SEG_SCAN_LZB_EN
    logic [N_DIGITS-1:0] lead_zero;
    logic                zero_run;
`endif

    // Slot timing: cnt walks through one digit slot, and idx advances at each slot end
    always_comb begin
        slot_end = (cnt == CNT_MAX);
        wrap     = slot_end && (idx == IDX_MAX);
        cnt_next = slot_end ? '0 : cnt + 1'b1;
        idx_next = idx;
        if (slot_end) begin
            idx_next = wrap ? '0 : idx + 1'b1;
        end
    end

    // The FSM follows the slot counter and stays in BLANK for the first BLANK_CYC cycles of each slot
    always_comb begin
        state_next = state;
        case (state)
            BLANK:   if (!(cnt_next < BLANK_LIM)) state_next = SHOW;
            SHOW:    if (cnt_next < BLANK_LIM)    state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // Load handshake: fill pending when it is empty, and move pending into active only on a frame wrap
    always_comb begin
        xfer           = bus.load_valid && !pend_flag;
        active_next    = active;
        pending_next   = pending;
        pend_flag_next = pend_flag;
        if (wrap && pend_flag) begin
            active_next    = pending;
            pend_flag_next = 1'b0;
        end else if (xfer) begin
            pending_next   = bus.load_data;
            pend_flag_next = 1'b1;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // Flag each digit whose value and all higher digits are zero, so its anode can stay off
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (active_next[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
    end
`endif

    // Display drive for the upcoming cycle: registered code, segment pattern and anode enables
    always_comb begin
        bcd_next = active_next[4*idx_next +: 4];
        seg_next = 7'h7F;
        an_next  = '1;
        if (state_next == SHOW) begin
            seg_next = bus.seg_in;
            for (int k = 0; k < N_DIGITS; k++) begin
                an_next[k] = (idx_next != IDX_W'(k));
            end
`ifdef SEG_SCAN_LZB_EN
            for (int k = 1; k < N_DIGITS; k++) begin
                if (lead_zero[k]) begin
                    an_next[k] = 1'b1;
                end
            end
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

    // Counters, display buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            active    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
            bcd_reg   <= 4'd0;
            seg_reg   <= 7'h7F;
            an_reg    <= '1;
            fd_reg    <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            idx       <= idx_next;
            active    <= active_next;
            pending   <= pending_next;
            pend_flag <= pend_flag_next;
            bcd_reg   <= bcd_next;
            seg_reg   <= seg_next;
            an_reg    <= an_next;
            fd_reg    <= wrap;
        end
    end

    assign bus.load_ready = ~pend_flag;
    assign bus.bcd_code   = bcd_reg;
    assign bus.seg_out    = seg_reg;
    assign bus.an_out     = an_reg;
    assign bus.frame_done = fd_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed testbench for seg_scan_ctrl with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// It checks the leading-zero expectations according to whether SEG_SCAN_LZB_EN is defined.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FRM = N * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    seg_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Reference active-low decoder (bit order gfedcba)
    function automatic logic [6:0] dec7(input logic [3:0] c);
        case (c)
            4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;  4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;  4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;  4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;  4'hE: dec7 = 7'h06;  4'hF: dec7 = 7'h0E;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    assign bus.seg_in = dec7(bus.bcd_code);

    // Expected anodes for position c within a slot, with all digits shown
    function automatic logic [3:0] an_for(input int c, input int slot);
        logic [3:0] one;
        one = 4'b0001 << slot;
        an_for = (c < BLK) ? 4'hF : ~one;
    endfunction

    // Advance one clock and track the cycle index since the last reset edge
    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
        #1;
    endtask

    task automatic test_reset();
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++; if (bus.an_out !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_an: got %h want %h", bus.an_out, 4'hF); end
        n_checks++; if (bus.seg_out !== 7'h7F) begin n_fail++; $display("[TB] FAIL reset_seg: got %h want %h", bus.seg_out, 7'h7F); end
        n_checks++; if (bus.bcd_code !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_bcd: got %h want 0", bus.bcd_code); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", bus.load_ready); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fd: got %b want 0", bus.frame_done); end
        tick();
        n_checks++; if (bus.an_out !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_blank1: got %h want %h", bus.an_out, 4'hF); end
        tick();
        n_checks++; if (bus.an_out !== 4'b1110) begin n_fail++; $display("[TB] FAIL first_show_an: got %b want 1110", bus.an_out); end
        n_checks++; if (bus.seg_out !== 7'h40) begin n_fail++; $display("[TB] FAIL first_show_seg: got %h want 40", bus.seg_out); end
    endtask

    task automatic test_load();
        logic [3:0] codes [4];
        int guard;
        int low;
        codes = '{4'd4, 4'd3, 4'd2, 4'd1};
        bus.load_data  = 16'h1234;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL load_busy: got %b want 0", bus.load_ready); end
        guard = 0;
        while ((cyc % FRM) != 0 && guard < 2 * FRM) begin tick(); guard++; end
        n_checks++; if ((cyc % FRM) != 0) begin n_fail++; $display("[TB] FAIL load_wrap_wait: cycle %0d not at a frame start", cyc); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL load_ready_after_commit: got %b want 1", bus.load_ready); end
        low = 0;
        for (int j = 0; j < FRM; j++) begin
            int slot;
            int c;
            slot = j / DIV;
            c    = j % DIV;
            n_checks++; if (bus.bcd_code !== codes[slot]) begin n_fail++; $display("[TB] FAIL load_bcd j=%0d: got %h want %h", j, bus.bcd_code, codes[slot]); end
            n_checks++; if (bus.an_out !== an_for(c, slot)) begin n_fail++; $display("[TB] FAIL load_an j=%0d: got %b want %b", j, bus.an_out, an_for(c, slot)); end
            n_checks++; if (bus.seg_out !== ((c < BLK) ? 7'h7F : dec7(codes[slot]))) begin n_fail++; $display("[TB] FAIL load_seg j=%0d: got %h", j, bus.seg_out); end
            if (bus.an_out[slot] == 1'b0) low++;
            if (c == DIV - 1) begin
                n_checks++; if (low != DIV - BLK) begin n_fail++; $display("[TB] FAIL load_low_count slot=%0d: got %0d want %0d", slot, low, DIV - BLK); end
                low = 0;
            end
            tick();
        end
    endtask

    task automatic test_free_run();
        int last;
        int pulses;
        last   = -1;
        pulses = 0;
        for (int j = 0; j < 4 * FRM; j++) begin
            n_checks++; if (bus.frame_done !== ((cyc % FRM) == 0)) begin n_fail++; $display("[TB] FAIL fd_pulse cyc=%0d: got %b", cyc, bus.frame_done); end
            n_checks++; if ($countones(~bus.an_out) > 1) begin n_fail++; $display("[TB] FAIL an_onehot cyc=%0d: got %b want at most one low", cyc, bus.an_out); end
            if (bus.frame_done === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_checks++; if (cyc - last != FRM) begin n_fail++; $display("[TB] FAIL fd_period: got %0d want %0d", cyc - last, FRM); end
                end
                last = cyc;
            end
            tick();
        end
        n_checks++; if (pulses != 4) begin n_fail++; $display("[TB] FAIL fd_count: got %0d want 4", pulses); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   guard;
        bus.load_data  = 16'h1111;
        bus.load_valid = 1'b1;
        guard = 0;
        do begin acc = bus.load_ready; tick(); guard++; end while (!acc && guard < 3 * FRM);
        n_checks++; if (!acc) begin n_fail++; $display("[TB] FAIL b2b_first_accept: got no transfer, want one"); end
        bus.load_data = 16'h2222;
        guard = 0;
        do begin
            n_checks++; if (bus.load_ready !== ((cyc % FRM) == 0)) begin n_fail++; $display("[TB] FAIL b2b_ready cyc=%0d: got %b", cyc, bus.load_ready); end
            acc = bus.load_ready;
            tick();
            guard++;
        end while (!acc && guard < 3 * FRM);
        bus.load_valid = 1'b0;
        n_checks++; if (!acc) begin n_fail++; $display("[TB] FAIL b2b_second_accept: got no transfer, want one"); end
        n_checks++; if ((cyc % FRM) != 1) begin n_fail++; $display("[TB] FAIL b2b_accept_time: got frame offset %0d want 1", cyc % FRM); end
        while ((cyc % FRM) != 0) begin
            n_checks++; if (bus.bcd_code !== 4'd1) begin n_fail++; $display("[TB] FAIL b2b_show1 cyc=%0d: got %h want 1", cyc, bus.bcd_code); end
            tick();
        end
        for (int j = 0; j < FRM; j++) begin
            n_checks++; if (bus.bcd_code !== 4'd2) begin n_fail++; $display("[TB] FAIL b2b_show2 j=%0d: got %h want 2", j, bus.bcd_code); end
            n_checks++; if (bus.an_out !== an_for(j % DIV, j / DIV)) begin n_fail++; $display("[TB] FAIL b2b_an j=%0d: got %b", j, bus.an_out); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_an;
        int guard;
        bus.load_data  = 16'h9999;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_pending: got %b want 0", bus.load_ready); end
        guard = 0;
        while ((cyc % FRM) != 2 * DIV + 4 && guard < FRM) begin tick(); guard++; end
        n_checks++; if (bus.an_out !== 4'b1011) begin n_fail++; $display("[TB] FAIL mid_digit2: got %b want 1011", bus.an_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.an_out !== 4'hF) begin n_fail++; $display("[TB] FAIL mid_rst_an: got %h want F", bus.an_out); end
        n_checks++; if (bus.seg_out !== 7'h7F) begin n_fail++; $display("[TB] FAIL mid_rst_seg: got %h want 7F", bus.seg_out); end
        n_checks++; if (bus.bcd_code !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_rst_bcd: got %h want 0", bus.bcd_code); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_ready: got %b want 1", bus.load_ready); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_fd: got %b want 0", bus.frame_done); end
        for (int j = 0; j < FRM + DIV; j++) begin
            int slot;
            slot   = (cyc / DIV) % N;
            exp_an = an_for(cyc % DIV, slot);
`ifdef SEG_SCAN_LZB_EN
            if (slot > 0) exp_an = 4'hF;
`endif
            n_checks++; if (bus.bcd_code !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_zero_bcd cyc=%0d: got %h want 0", cyc, bus.bcd_code); end
            n_checks++; if (bus.an_out !== exp_an) begin n_fail++; $display("[TB] FAIL mid_zero_an cyc=%0d: got %b want %b", cyc, bus.an_out, exp_an); end
            if ((cyc % DIV) < BLK || exp_an != 4'hF) begin
                n_checks++; if (bus.seg_out !== (((cyc % DIV) < BLK) ? 7'h7F : 7'h40)) begin n_fail++; $display("[TB] FAIL mid_zero_seg cyc=%0d: got %h", cyc, bus.seg_out); end
            end
            tick();
        end
    endtask

    task automatic test_lzb();
        logic [3:0] codes [4];
        logic [3:0] mask;
        logic [3:0] exp_an;
        int guard;
        codes = '{4'd0, 4'd5, 4'd0, 4'd0};
`ifdef SEG_SCAN_LZB_EN
        mask = 4'b0011;
`else
        mask = 4'b1111;
`endif
        bus.load_data  = 16'h0050;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        guard = 0;
        while ((cyc % FRM) != 0 && guard < 2 * FRM) begin tick(); guard++; end
        for (int j = 0; j < FRM; j++) begin
            int slot;
            int c;
            slot   = j / DIV;
            c      = j % DIV;
            exp_an = mask[slot] ? an_for(c, slot) : 4'hF;
            n_checks++; if (bus.bcd_code !== codes[slot]) begin n_fail++; $display("[TB] FAIL lzb_bcd j=%0d: got %h want %h", j, bus.bcd_code, codes[slot]); end
            n_checks++; if (bus.an_out !== exp_an) begin n_fail++; $display("[TB] FAIL lzb_an j=%0d: got %b want %b", j, bus.an_out, exp_an); end
            if (mask[slot] && c >= BLK) begin
                n_checks++; if (bus.seg_out !== dec7(codes[slot])) begin n_fail++; $display("[TB] FAIL lzb_seg j=%0d: got %h want %h", j, bus.seg_out, dec7(codes[slot])); end
            end
            tick();
        end
    endtask

    // Run the scenarios in order, then print the summary line
    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        test_reset();
        test_load();
        test_free_run();
        test_back_to_back();
        test_reset_mid();
        test_lzb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the bench itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
